cpu_mem_responder: RTL

//  Memory-side responder for the CPU bus (en/rdwr/addr/data). Holds program and data

---
 rtl/cpu_mem_responder_if.sv | 14 +
 rtl/cpu_mem_responder.sv | 107 ++++++++++
 2 files changed

// File: rtl/cpu_mem_responder_if.sv
// CPU-side memory bus: request (en/rdwr/addr/wdata) and registered read data.
// The CPU drives the master modport; the memory responder takes the slave modport.
interface cpu_mem_responder_if #(
  parameter int unsigned AW = 12
);
  logic          en;
  logic          rdwr;
  logic [AW-1:0] addr;
  logic [15:0]   wdata;
  logic [15:0]   rdata;

  modport master (output en, rdwr, addr, wdata, input rdata);
  modport slave  (input en, rdwr, addr, wdata, output rdata);
endinterface

// File: rtl/cpu_mem_responder.sv
// On-chip word memory answering CPU reads (1-cycle latency) and writes, plus a
// byte-serial loader that fills the array while load_en holds the CPU in reset.
module cpu_mem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  cpu_mem_responder_if.slave       bus,
  input  logic                     load_en,
  input  logic                     load_valid,
  input  logic [7:0]               load_byte,
  output logic [AW-1:0]            load_ptr,
  output logic                     load_wrap
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic {L_HI, L_LO} load_state_t;

  logic [15:0]   r_mem [DEPTH];
  logic [15:0]   r_rdata;
  logic [PW-1:0] r_ptr;
  logic          r_wrap;
  logic [7:0]    r_hi;
  logic          r_load_en_d;
  load_state_t   r_state, w_state_n;

  logic          w_in_range;
  logic          w_rise;
  logic          w_hi_ld;
  logic          w_commit;
  logic          w_cpu_rd;
  logic          w_cpu_wr;
  logic          w_we;
  logic [PW-1:0] w_waddr;
  logic [15:0]   w_wdata;

  assign w_in_range = (32'(bus.addr) < DEPTH);
  assign w_rise     = load_en & ~r_load_en_d;
  assign w_cpu_rd   = ~load_en & bus.en & ~bus.rdwr;
  assign w_cpu_wr   = ~load_en & bus.en & bus.rdwr & w_in_range;

  // A strobe on the load_en rising cycle is always the high byte, whatever
  // state the FSM was left in.
  always_comb begin
    w_state_n = r_state;
    w_hi_ld   = 1'b0;
    w_commit  = 1'b0;
    if (!load_en) begin
      w_state_n = L_HI;
    end else if (load_valid) begin
      if (w_rise || r_state == L_HI) begin
        w_hi_ld   = 1'b1;
        w_state_n = L_LO;
      end else begin
        w_commit  = 1'b1;
        w_state_n = L_HI;
      end
    end else if (w_rise) begin
      w_state_n = L_HI;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= L_HI;
      r_load_en_d <= 1'b0;
      r_hi        <= '0;
      r_ptr       <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_load_en_d <= load_en;
      if (w_hi_ld) r_hi <= load_byte;
      if (w_rise) begin
        r_ptr  <= '0;
        r_wrap <= 1'b0;
      end else if (w_commit) begin
        r_ptr <= r_ptr + PW'(1);
        if (r_ptr == PW'(DEPTH - 1)) r_wrap <= 1'b1;
      end
    end
  end

  // Loader and CPU writes never coincide: CPU requests are gated by load_en.
  assign w_we    = w_commit | w_cpu_wr;
  assign w_waddr = w_commit ? r_ptr : bus.addr[PW-1:0];
  assign w_wdata = w_commit ? {r_hi, load_byte} : bus.wdata;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_cpu_rd) begin
      r_rdata <= w_in_range ? r_mem[bus.addr[PW-1:0]] : '0;
    end
  end

  assign bus.rdata = r_rdata;
  assign load_ptr  = AW'(r_ptr);
  assign load_wrap = r_wrap;

endmodule
